// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch digit chain:
//   - sw_state_t  : run-control FSM encoding (STOPPED / RUNNING / DONE)
//   - digit_mod() : modulus of digit i (even digits MOD_EVEN, odd digits MOD_ODD)
//   - clamp_digit(): limits a loaded digit value to modulus-1
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_DONE    = 2'd2
    } sw_state_t;

    // Alternating modulus, e.g. 10/6 gives an ss / mm / hh-style chain.
    function automatic int digit_mod(input int i, input int mod_even, input int mod_odd);
        return (i % 2 == 0) ? mod_even : mod_odd;
    endfunction

    // Out-of-range load values saturate at the largest legal digit value.
    function automatic int clamp_digit(input int value, input int modulus);
        return (value >= modulus) ? modulus - 1 : value;
    endfunction

endpackage

// File: rtl/stopwatch_digit_chain_mod_digit.sv
// -----------------------------------------------------------------------------
// mod_digit
// One modulo-MOD up/down digit of the stopwatch chain.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   en        : step this digit by one in the direction given by dir
//   dir       : 0 = increment (MOD-1 wraps to 0), 1 = decrement (0 wraps to MOD-1)
//   load      : take load_d (clamped to MOD-1)
//   load_d    : raw digit value to load
//   clr       : synchronous clear to 0 (highest priority)
//   q         : current digit value
//   at_max    : q == MOD-1
//   at_zero   : q == 0
// -----------------------------------------------------------------------------
module mod_digit
    import stopwatch_pkg::*;
#(
    parameter int MOD     = 10,
    parameter int DIGIT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               dir,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_d,
    input  logic               clr,
    output logic [DIGIT_W-1:0] q,
    output logic               at_max,
    output logic               at_zero
);

    localparam logic [DIGIT_W-1:0] MAX_Q = DIGIT_W'(MOD - 1);
    localparam logic [DIGIT_W-1:0] ONE_Q = DIGIT_W'(1);

    logic [DIGIT_W-1:0] load_q;

    assign load_q  = DIGIT_W'(clamp_digit(int'(load_d), MOD));
    assign at_max  = (q == MAX_Q);
    assign at_zero = (q == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= load_q;
        end else if (en) begin
            if (dir) q <= at_zero ? MAX_Q : q - ONE_Q;
            else     q <= at_max  ? '0    : q + ONE_Q;
        end
    end

endmodule

// File: rtl/stopwatch_digit_chain.sv
// -----------------------------------------------------------------------------
// stopwatch_digit_chain
// NUM_DIGITS cascaded modulo digits with run/stop/done control, parallel
// load, lap freeze and overflow/expiry flags.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   tick         : count strobe (counted only if RUNNING before the edge)
//   start_stop   : toggles STOPPED <-> RUNNING
//   clear        : synchronous clear of digits, flags and lap
//   load         : parallel load of load_value (ignored while RUNNING)
//   load_value   : packed digits, digit 0 in the low DIGIT_W bits
//   dir          : 0 = count up, 1 = count down
//   lap          : toggles lap freeze of display_out
//   count_out    : live count
//   display_out  : live count, or lap snapshot while lap_active
//   running      : state == RUNNING
//   lap_active   : display frozen on snapshot
//   done         : down-count reached zero (state == DONE)
//   overflow     : sticky, top digit wrapped while counting up
//   carry_out    : one-cycle pulse on top-digit wrap
// -----------------------------------------------------------------------------
module stopwatch_digit_chain
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4,
    parameter int MOD_EVEN   = 10,
    parameter int MOD_ODD    = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick,
    input  logic                          start_stop,
    input  logic                          clear,
    input  logic                          load,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] load_value,
    input  logic                          dir,
    input  logic                          lap,
    output logic [NUM_DIGITS*DIGIT_W-1:0] count_out,
    output logic [NUM_DIGITS*DIGIT_W-1:0] display_out,
    output logic                          running,
    output logic                          lap_active,
    output logic                          done,
    output logic                          overflow,
    output logic                          carry_out
);

    localparam int W = NUM_DIGITS * DIGIT_W;

    sw_state_t             state;
    logic [W-1:0]          snapshot;
    logic [NUM_DIGITS-1:0] at_max, at_zero;
    logic [NUM_DIGITS-1:0] up_en, dn_en, digit_en;
    logic                  all_max, all_zero, upper_zero, one_left;
    logic                  tick_go, count_go, load_go, down_blocked, hit_zero, top_wrap;

    // Ripple enables: a digit steps when every lower digit is at its wrap point.
    // NOTE: every always_comb output is given a default before any branch so
    // no latch can be inferred.
    always_comb begin
        up_en      = '0;
        dn_en      = '0;
        upper_zero = 1'b1;
        up_en[0]   = 1'b1;
        dn_en[0]   = 1'b1;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            up_en[i]   = up_en[i-1] & at_max[i-1];
            dn_en[i]   = dn_en[i-1] & at_zero[i-1];
            upper_zero = upper_zero & at_zero[i];
        end
    end

    assign all_max  = &at_max;
    assign all_zero = &at_zero;
    assign one_left = upper_zero && (count_out[DIGIT_W-1:0] == DIGIT_W'(1));

    assign tick_go      = tick && (state == ST_RUNNING) && !clear;
    // A down-tick at all-zero would wrap to all-max; hold at zero instead.
    assign down_blocked = dir && all_zero;
    assign count_go     = tick_go && !down_blocked;
    assign digit_en     = count_go ? (dir ? dn_en : up_en) : '0;
    assign hit_zero     = tick_go && dir && (one_left || all_zero);
    assign top_wrap     = count_go && !dir && all_max;
    assign load_go      = load && !clear && (state != ST_RUNNING);

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        mod_digit #(
            .MOD     (digit_mod(i, MOD_EVEN, MOD_ODD)),
            .DIGIT_W (DIGIT_W)
        ) u_digit (
            .clk     (clk),
            .rst     (rst),
            .en      (digit_en[i]),
            .dir     (dir),
            .load    (load_go),
            .load_d  (load_value[i*DIGIT_W +: DIGIT_W]),
            .clr     (clear),
            .q       (count_out[i*DIGIT_W +: DIGIT_W]),
            .at_max  (at_max[i]),
            .at_zero (at_zero[i])
        );
    end

    // Control FSM with registered status outputs.
    // NOTE: the lap snapshot is a plain register, so it takes the reset like
    // every other flop here; no memory needs special reset handling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_STOPPED;
            running    <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            carry_out  <= 1'b0;
            lap_active <= 1'b0;
            snapshot   <= '0;
        end else begin
            carry_out <= top_wrap;
            if (top_wrap) overflow <= 1'b1;

            // Lap capture uses the pre-update count of this edge.
            if (clear) begin
                lap_active <= 1'b0;
            end else if (lap) begin
                if (!lap_active) begin
                    snapshot   <= count_out;
                    lap_active <= 1'b1;
                end else begin
                    lap_active <= 1'b0;
                end
            end

            if (clear) begin
                state    <= ST_STOPPED;
                running  <= 1'b0;
                done     <= 1'b0;
                overflow <= 1'b0;
            end else if (load_go) begin
                state   <= ST_STOPPED;
                running <= 1'b0;
                done    <= 1'b0;
            end else begin
                unique case (state)
                    ST_STOPPED: begin
                        if (start_stop && !down_blocked) begin
                            state   <= ST_RUNNING;
                            running <= 1'b1;
                        end
                    end
                    ST_RUNNING: begin
                        // Expiry wins over a simultaneous stop: the count is zero either way.
                        if (hit_zero) begin
                            state   <= ST_DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end else if (start_stop) begin
                            state   <= ST_STOPPED;
                            running <= 1'b0;
                        end
                    end
                    ST_DONE: begin
                        // Only clear, load or rst leave DONE.
                    end
                    default: begin
                        state   <= ST_STOPPED;
                        running <= 1'b0;
                        done    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign display_out = lap_active ? snapshot : count_out;

endmodule

// File: tb/tb_stopwatch_digit_chain.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_digit_chain
// Directed scenarios plus a randomized phase, all compared every cycle against
// a reference model that keeps the count as a single integer (elapsed ticks)
// and converts it to mixed-radix digits only for comparison.
// -----------------------------------------------------------------------------
module tb_stopwatch_digit_chain;

    localparam int N     = 4;
    localparam int DW    = 4;
    localparam int ME    = 10;
    localparam int MO    = 6;
    localparam int W     = N * DW;
    localparam int TOTAL = ME * MO * ME * MO;

    localparam int M_STOP = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tick = 1'b0, start_stop = 1'b0, clear = 1'b0, load = 1'b0;
    logic         dir = 1'b0, lap = 1'b0;
    logic [W-1:0] load_value = '0;
    logic [W-1:0] count_out, display_out;
    logic         running, lap_active, done, overflow, carry_out;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int           m_n;
    int           m_state;
    logic         m_lap, m_ovf, m_carry;
    logic [W-1:0] m_snap;

    stopwatch_digit_chain #(
        .NUM_DIGITS (N),
        .DIGIT_W    (DW),
        .MOD_EVEN   (ME),
        .MOD_ODD    (MO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .start_stop  (start_stop),
        .clear       (clear),
        .load        (load),
        .load_value  (load_value),
        .dir         (dir),
        .lap         (lap),
        .count_out   (count_out),
        .display_out (display_out),
        .running     (running),
        .lap_active  (lap_active),
        .done        (done),
        .overflow    (overflow),
        .carry_out   (carry_out)
    );

    always #5 clk = ~clk;

    function automatic int modulus_of(input int i);
        return (i % 2 == 0) ? ME : MO;
    endfunction

    function automatic logic [W-1:0] to_digits(input int n);
        logic [W-1:0] d;
        int           rem;
        d   = '0;
        rem = n;
        for (int i = 0; i < N; i++) begin
            d[i*DW +: DW] = DW'(rem % modulus_of(i));
            rem           = rem / modulus_of(i);
        end
        return d;
    endfunction

    function automatic int from_load(input logic [W-1:0] v);
        int n, weight, dv;
        n      = 0;
        weight = 1;
        for (int i = 0; i < N; i++) begin
            dv = int'(v[i*DW +: DW]);
            if (dv >= modulus_of(i)) dv = modulus_of(i) - 1;
            n      = n + dv * weight;
            weight = weight * modulus_of(i);
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_n     = 0;
        m_state = M_STOP;
        m_lap   = 1'b0;
        m_ovf   = 1'b0;
        m_carry = 1'b0;
        m_snap  = '0;
    endtask

    task automatic model_step(input logic tk, input logic ss, input logic cl, input logic ld,
                              input logic [W-1:0] lv, input logic d, input logic lp);
        int s;
        s       = m_state;
        m_carry = 1'b0;
        if (cl) m_lap = 1'b0;
        else if (lp) begin
            if (!m_lap) begin
                m_snap = to_digits(m_n);
                m_lap  = 1'b1;
            end else begin
                m_lap = 1'b0;
            end
        end
        if (cl) begin
            m_n     = 0;
            m_state = M_STOP;
            m_ovf   = 1'b0;
        end else if (ld && s != M_RUN) begin
            m_n     = from_load(lv);
            m_state = M_STOP;
        end else if (s == M_STOP) begin
            if (ss && !(d && m_n == 0)) m_state = M_RUN;
        end else if (s == M_RUN) begin
            if (tk) begin
                if (!d) begin
                    if (m_n == TOTAL - 1) begin
                        m_n     = 0;
                        m_carry = 1'b1;
                        m_ovf   = 1'b1;
                    end else begin
                        m_n++;
                    end
                end else begin
                    if (m_n > 0) m_n--;
                    if (m_n == 0) m_state = M_DONE;
                end
            end
            if (ss && m_state == M_RUN) m_state = M_STOP;
        end
    endtask

    task automatic check_all(input string tag);
        logic [W-1:0] exp_count;
        exp_count = to_digits(m_n);
        check({tag, "/count"},   32'(count_out),   32'(exp_count));
        check({tag, "/display"}, 32'(display_out), 32'(m_lap ? m_snap : exp_count));
        check({tag, "/running"}, 32'(running),     32'(m_state == M_RUN));
        check({tag, "/done"},    32'(done),        32'(m_state == M_DONE));
        check({tag, "/lap"},     32'(lap_active),  32'(m_lap));
        check({tag, "/ovf"},     32'(overflow),    32'(m_ovf));
        check({tag, "/carry"},   32'(carry_out),   32'(m_carry));
    endtask

    // One clock cycle: drive on the falling edge, model the rising edge, check 1 time unit later.
    task automatic cycle(input logic tk, input logic ss, input logic cl, input logic ld,
                         input logic [W-1:0] lv, input logic d, input logic lp, input string tag);
        @(negedge clk);
        tick       = tk;
        start_stop = ss;
        clear      = cl;
        load       = ld;
        load_value = lv;
        dir        = d;
        lap        = lp;
        @(posedge clk);
        model_step(tk, ss, cl, ld, lv, d, lp);
        #1;
        tick       = 1'b0;
        start_stop = 1'b0;
        clear      = 1'b0;
        load       = 1'b0;
        lap        = 1'b0;
        check_all(tag);
    endtask

    task automatic ticks(input int n, input logic d, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, d, 1'b0, tag);
    endtask

    task automatic do_start(input logic d);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, d, 1'b0, "start_stop");
    endtask

    task automatic do_clear();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, dir, 1'b0, "clear");
    endtask

    task automatic do_load(input logic [W-1:0] v);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, v, dir, 1'b0, "load");
    endtask

    task automatic do_lap();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, dir, 1'b1, "lap");
    endtask

    initial begin
        logic         rd, rt, rs, rc, rl, rp;
        logic [W-1:0] rv;

        // Reset state
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Up-count through a full wrap of the chain
        do_start(1'b0);
        ticks(59, 1'b0, "up");
        check("up_0059", 32'(count_out), 32'h0059);
        ticks(1, 1'b0, "up");
        check("up_0100", 32'(count_out), 32'h0100);
        ticks(TOTAL - 61, 1'b0, "up");
        check("up_5959", 32'(count_out), 32'h5959);
        check("up_no_ovf", 32'(overflow), 32'h0);
        ticks(1, 1'b0, "wrap");
        check("wrap_count", 32'(count_out), 32'h0000);
        check("wrap_carry", 32'(carry_out), 32'h1);
        check("wrap_ovf",   32'(overflow),  32'h1);
        ticks(1, 1'b0, "after_wrap");
        check("carry_one_cycle", 32'(carry_out), 32'h0);
        do_start(1'b0);

        // Down-count to expiry
        do_clear();
        do_load(16'h0100);
        do_start(1'b1);
        ticks(60, 1'b1, "down");
        check("down_zero", 32'(count_out), 32'h0000);
        check("down_done", 32'(done),      32'h1);
        check("down_stop", 32'(running),   32'h0);
        ticks(5, 1'b1, "done_ticks");
        do_start(1'b1);
        check("done_hold", 32'(done),      32'h1);
        check("done_zero", 32'(count_out), 32'h0000);
        do_clear();
        check("done_clr",  32'(done),      32'h0);
        do_start(1'b1);
        check("start_at_zero_down", 32'(running), 32'h0);

        // Load clamp and load-while-running
        do_load(16'h0F7A);
        check("clamp", 32'(count_out), 32'h0959);
        do_start(1'b0);
        ticks(1, 1'b0, "clamp_tick");
        check("clamp_tick", 32'(count_out), 32'h1000);
        do_load(16'h1234);
        check("load_running", 32'(count_out), 32'h1000);
        do_start(1'b0);

        // Lap freeze
        do_clear();
        do_load(16'h0012);
        do_start(1'b0);
        do_lap();
        ticks(8, 1'b0, "lap_run");
        check("lap_disp",  32'(display_out), 32'h0012);
        check("lap_count", 32'(count_out),   32'h0020);
        do_lap();
        check("lap_release", 32'(display_out), 32'h0020);
        do_start(1'b0);

        // Simultaneous events
        do_clear();
        do_load(16'h0033);
        do_start(1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b0, "all_events");
        check("all_events", 32'(count_out), 32'h0000);
        do_load(16'h0005);
        do_start(1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "stop_tick");
        check("stop_tick", 32'(count_out), 32'h0006);
        check("stop_tick_state", 32'(running), 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "start_tick");
        check("start_tick", 32'(count_out), 32'h0006);
        check("start_tick_state", 32'(running), 32'h1);
        do_start(1'b0);

        // Asynchronous reset mid-run with lap active
        do_clear();
        do_load(16'h0042);
        do_start(1'b0);
        do_lap();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        ticks(3, 1'b0, "post_rst_ticks");
        check("post_rst_idle", 32'(count_out), 32'h0000);
        do_start(1'b0);
        ticks(1, 1'b0, "post_rst_run");
        check("post_rst_run", 32'(count_out), 32'h0001);

        // Randomized phase
        rd = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) rd = ~rd;
            rt = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 9) == 0);
            rc = ($urandom_range(0, 39) == 0);
            rl = ($urandom_range(0, 19) == 0);
            rp = ($urandom_range(0, 11) == 0);
            rv = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            cycle(rt, rs, rc, rl, rv, rd, rp, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
